ex_stage: RTL

Execute stage of the 8-bit MIPS pipeline, sitting directly downstream of the ID/EX pipeline register and consuming its outputs unchanged. It has three parts:
- operand forwarding from the two younger-result sources;
- an 8-bit ALU driven by the 3-bit ALU signal;
- the EX/MEM pipeline register, with stall and flush control.

All outputs are registered; nothing combinational leaves the block.

---
 rtl/mips_pkg.sv | 31 +++
 rtl/ex_stage_if.sv | 39 +++
 rtl/alu8.sv | 49 ++++
 rtl/ex_stage.sv | 97 +++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the 8-bit MIPS pipeline: widths, ALU opcodes and
// forward-select encoding.
package mips_pkg;

  localparam int unsigned DW_DEFAULT = 8;
  localparam int unsigned RW_DEFAULT = 5;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_NOR  = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;
  localparam logic [2:0] ALU_SLTU = 3'b111;

  localparam logic [1:0] FWD_REG   = 2'd0;
  localparam logic [1:0] FWD_MEMWB = 2'd1;
  localparam logic [1:0] FWD_EXMEM = 2'd2;

  // EX/MEM is the younger result, so it wins when both sources match.
  function automatic logic [1:0] fwd_sel(input logic exmem_hit, input logic memwb_hit);
    if (exmem_hit) begin
      return FWD_EXMEM;
    end else if (memwb_hit) begin
      return FWD_MEMWB;
    end
    return FWD_REG;
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Signal bundle between the ID/EX register, MEM/WB write-back and the execute stage.
interface ex_stage_if
  import mips_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT,
  parameter int unsigned RW = RW_DEFAULT
);

  logic          stall;
  logic          flush;
  logic [2:0]    aluSig_in;
  logic          WB_in;
  logic [DW-1:0] R1_in;
  logic [DW-1:0] R2_in;
  logic [RW-1:0] rd_in;
  logic [RW-1:0] rs_in;
  logic [RW-1:0] rt_in;
  logic          memwb_we;
  logic [RW-1:0] memwb_rd;
  logic [DW-1:0] memwb_data;
  logic [DW-1:0] res_out;
  logic          WB_out;
  logic [RW-1:0] rd_out;
  logic          zero_out;
  logic          ovf_out;

  modport master (
    output stall, flush, aluSig_in, WB_in, R1_in, R2_in, rd_in, rs_in, rt_in,
           memwb_we, memwb_rd, memwb_data,
    input  res_out, WB_out, rd_out, zero_out, ovf_out
  );

  modport slave (
    input  stall, flush, aluSig_in, WB_in, R1_in, R2_in, rd_in, rs_in, rt_in,
           memwb_we, memwb_rd, memwb_data,
    output res_out, WB_out, rd_out, zero_out, ovf_out
  );

endinterface

// File: rtl/alu8.sv
// Combinational ALU: result, zero flag and signed overflow (ADD/SUB only).
module alu8
  import mips_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [2:0]    op,
  output logic [DW-1:0] y,
  output logic          zero,
  output logic          ovf
);

  logic [DW-1:0] sum;
  logic [DW-1:0] diff;
  logic          lt_s;
  logic          lt_u;

  assign sum  = a + b;
  assign diff = a - b;
  assign lt_s = $signed(a) < $signed(b);
  assign lt_u = a < b;

  always_comb begin
    y   = '0;
    ovf = 1'b0;
    unique case (op)
      ALU_ADD: begin
        y   = sum;
        ovf = (a[DW-1] == b[DW-1]) && (sum[DW-1] != a[DW-1]);
      end
      ALU_SUB: begin
        y   = diff;
        ovf = (a[DW-1] != b[DW-1]) && (diff[DW-1] != a[DW-1]);
      end
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_NOR:  y = ~(a | b);
      ALU_SLT:  y = {{(DW-1){1'b0}}, lt_s};
      ALU_SLTU: y = {{(DW-1){1'b0}}, lt_u};
      default:  y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU and the EX/MEM pipeline register
// with flush-over-stall control.
module ex_stage
  import mips_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT,
  parameter int unsigned RW = RW_DEFAULT
) (
  input logic      clk,
  input logic      rst,
  ex_stage_if.slave bus
);

  logic [DW-1:0] res_q;
  logic          wb_q;
  logic [RW-1:0] rd_q;
  logic          zero_q;
  logic          ovf_q;

  logic [1:0]    sel_a;
  logic [1:0]    sel_b;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [DW-1:0] alu_y;
  logic          alu_zero;
  logic          alu_ovf;

  logic exmem_valid;
  logic memwb_valid;

  // Register 0 is hard-wired, so a write to it never feeds a consumer.
  assign exmem_valid = wb_q && (rd_q != '0);
  assign memwb_valid = bus.memwb_we && (bus.memwb_rd != '0);

  assign sel_a = fwd_sel(exmem_valid && (rd_q == bus.rs_in),
                         memwb_valid && (bus.memwb_rd == bus.rs_in));
  assign sel_b = fwd_sel(exmem_valid && (rd_q == bus.rt_in),
                         memwb_valid && (bus.memwb_rd == bus.rt_in));

  always_comb begin
    op_a = bus.R1_in;
    unique case (sel_a)
      FWD_EXMEM: op_a = res_q;
      FWD_MEMWB: op_a = bus.memwb_data;
      default:   op_a = bus.R1_in;
    endcase
  end

  always_comb begin
    op_b = bus.R2_in;
    unique case (sel_b)
      FWD_EXMEM: op_b = res_q;
      FWD_MEMWB: op_b = bus.memwb_data;
      default:   op_b = bus.R2_in;
    endcase
  end

  alu8 #(
    .DW (DW)
  ) u_alu (
    .a    (op_a),
    .b    (op_b),
    .op   (bus.aluSig_in),
    .y    (alu_y),
    .zero (alu_zero),
    .ovf  (alu_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q  <= '0;
      wb_q   <= 1'b0;
      rd_q   <= '0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (bus.flush) begin
      res_q  <= '0;
      wb_q   <= 1'b0;
      rd_q   <= '0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (!bus.stall) begin
      res_q  <= alu_y;
      wb_q   <= bus.WB_in;
      rd_q   <= bus.rd_in;
      zero_q <= alu_zero;
      ovf_q  <= alu_ovf;
    end
  end

  assign bus.res_out  = res_q;
  assign bus.WB_out   = wb_q;
  assign bus.rd_out   = rd_q;
  assign bus.zero_out = zero_q;
  assign bus.ovf_out  = ovf_q;

endmodule
